vc_writeback_buffer: RTL and testbench
======================================

# vc_writeback_buffer

Dirty-line writeback buffer sitting directly downstream of the L1.5 victim cache. When the victim cache displaces a line in state M, the line is pushed here, queued in FIFO order, and issued to the L2/NoC writeback path with a valid/ready handshake. Entries are held until the L2 acknowledges them. A one-cycle-registered address lookup lets the L1.5 S1/S2 pipeline detect and forward lines whose writeback is still in flight.

## Interface
Parameters:
- ADDR_WIDTH, 36, line address width (tag 29 + index 7)
- DATA_WIDTH, 128, cache line width
- DEPTH, 4, number of entries; a power of two, at least 2

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- vc_wbb_push_val  in  1  victim cache presents a displaced dirty line
- vc_wbb_push_addr  in  ADDR_WIDTH  line address of the pushed line
- vc_wbb_push_data  in  DATA_WIDTH  line data of the pushed line
- wbb_vc_push_rdy  out  1  buffer can accept a push this cycle
- l15_wbb_lookup_val_s1  in  1  S1 lookup request
- l15_wbb_lookup_addr_s1  in  ADDR_WIDTH  S1 lookup address
- wbb_l15_hit_s2  out  1  S2 lookup hit (registered)
- wbb_l15_data_s2  out  DATA_WIDTH  S2 data of the hitting entry; 0 on miss
- wbb_noc_req_val  out  1  writeback request valid
- wbb_noc_req_addr  out  ADDR_WIDTH  writeback address
- wbb_noc_req_data  out  DATA_WIDTH  writeback data
- noc_wbb_req_rdy  in  1  downstream accepts the request
- noc_wbb_ack_val  in  1  L2 acknowledges the oldest issued writeback
- wbb_empty  out  1  no entries are pending or issued (used by fences)
- wbb_overflow  out  1  sticky error flag: a push arrived while not ready

## Operation
- Each entry has a state: FREE, PENDING (queued, not yet issued) or ISSUED (sent, awaiting ack).
- Three pointers, each log2(DEPTH) bits and wrapping modulo DEPTH: wr_ptr, iss_ptr, ack_ptr. An occupancy count is log2(DEPTH)+1 bits.
- Push:
  - A push fires when push_val is high and push_rdy is high.
  - push_rdy = (count < DEPTH), computed from registered count only. An ack in the same cycle does not make a full buffer ready.
  - On fire: entry[wr_ptr] gets addr and data, its state goes FREE->PENDING, wr_ptr++, count++.
  - If push_val is high while push_rdy is low, the push is dropped and wbb_overflow is set. It stays set until reset.
- Issue:
  - req_val is high when entry[iss_ptr] is PENDING. req_addr and req_data come from entry[iss_ptr].
  - On val & rdy, the entry goes PENDING->ISSUED and iss_ptr++.
- Ack:
  - Acks arrive in order. If entry[ack_ptr] is ISSUED at the start of the cycle, an ack moves it ISSUED->FREE, ack_ptr++ and count--.
  - An ack with no ISSUED entry is ignored. An ack does not free an entry that is issued in the same cycle.
- Simultaneous push and ack: count is unchanged, and both pointers advance.
- Lookup (S1):
  - Compares against all PENDING and ISSUED entries, plus a push firing in the same cycle (bypass).
  - An entry being acked in the same cycle still hits, because the pre-ack state is used.
  - Duplicate addresses are allowed. The youngest match wins, ordered by distance from ack_ptr, with the bypass push being the youngest.
  - Result is registered into hit_s2 and data_s2. If lookup_val is low, the next-cycle outputs are 0.
- wbb_empty = (count == 0).

## Timing
- Reset (async assert): all entries FREE, addr/data 0, pointers 0, count 0, overflow 0.
  - Outputs during and after reset: push_rdy=1, req_val=0, req_addr=0, req_data=0, hit_s2=0, data_s2=0, empty=1, overflow=0.
  - Reset mid-operation discards all entries with no writeback issued. Outstanding acks that arrive after deassert are ignored.
- A push in cycle N is visible in cycle N+1: req_val can rise, empty falls, and count is updated.
- Lookup in cycle N produces hit_s2/data_s2 in cycle N+1.
- req_val, req_addr and req_data stay stable while rdy is low. At most one issue per cycle, and back-to-back issues are allowed.
- Full at DEPTH entries: push_rdy is low in the cycle after the DEPTH-th push. It rises in the cycle after the first ack.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.

## Test plan
- Reset, then push A=0x000000100/D=0xAA..AA with rdy=1: req_val in the next cycle with the same addr/data. Ack one cycle after issue: empty=1 in the following cycle.
- Push 4 lines with rdy=0: push_rdy=0 after the 4th. A 5th push sets overflow=1 and is dropped. Release rdy and ack 4 times: issue order is 1,2,3,4, and overflow stays 1.
- Lookup 0x000000200 while it is PENDING, then while ISSUED, then on its ack cycle: hit_s2=1 with its data each time. Lookup the cycle after the ack: hit_s2=0, data_s2=0.
- Same-cycle push of 0x300/D1 and lookup of 0x300: hit_s2=1, data_s2=D1. Push 0x300/D2 later, then lookup: data_s2=D2 (youngest wins).
- 10 push/issue/ack sequences with DEPTH=4: pointers wrap correctly, no entry is lost or duplicated, and the NoC address order matches the push order.
- Assert rst_n low with 3 entries outstanding: req_val=0 and empty=1 immediately. A spurious ack after deassert leaves the state unchanged.

Source files
------------

// File: rtl/vc_writeback_buffer.sv
// -----------------------------------------------------------------------------
// vc_writeback_buffer
//
// Dirty-line writeback buffer downstream of the L1.5 victim cache. Displaced
// M-state lines are queued in FIFO order and issued to the L2/NoC writeback
// path with a valid/ready handshake. Each entry is held until the L2 acks it,
// so a registered address lookup lets the L1.5 S1/S2 pipeline forward lines
// whose writeback is still in flight.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   vc_wbb_push_val/addr/data     push of a displaced dirty line
//   wbb_vc_push_rdy               buffer can accept a push this cycle
//   l15_wbb_lookup_val_s1/addr_s1 S1 lookup request
//   wbb_l15_hit_s2/data_s2        registered S2 lookup result (data 0 on miss)
//   wbb_noc_req_val/addr/data     writeback request toward L2/NoC
//   noc_wbb_req_rdy               downstream accepts the request
//   noc_wbb_ack_val               L2 acks the oldest issued writeback
//   wbb_empty                     nothing pending or issued
//   wbb_overflow                  sticky: a push arrived while not ready
// -----------------------------------------------------------------------------
module vc_writeback_buffer #(
   parameter int ADDR_WIDTH = 36,
   parameter int DATA_WIDTH = 128,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  vc_wbb_push_val,
   input  logic [ADDR_WIDTH-1:0] vc_wbb_push_addr,
   input  logic [DATA_WIDTH-1:0] vc_wbb_push_data,
   output logic                  wbb_vc_push_rdy,
   input  logic                  l15_wbb_lookup_val_s1,
   input  logic [ADDR_WIDTH-1:0] l15_wbb_lookup_addr_s1,
   output logic                  wbb_l15_hit_s2,
   output logic [DATA_WIDTH-1:0] wbb_l15_data_s2,
   output logic                  wbb_noc_req_val,
   output logic [ADDR_WIDTH-1:0] wbb_noc_req_addr,
   output logic [DATA_WIDTH-1:0] wbb_noc_req_data,
   input  logic                  noc_wbb_req_rdy,
   input  logic                  noc_wbb_ack_val,
   output logic                  wbb_empty,
   output logic                  wbb_overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_FREE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_ISSUED  = 2'd2
   } ent_state_e;

   ent_state_e            state_q [DEPTH];
   ent_state_e            state_d [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_q  [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_d  [DEPTH];
   logic [DATA_WIDTH-1:0] data_q  [DEPTH];
   logic [DATA_WIDTH-1:0] data_d  [DEPTH];

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         iss_ptr_q, iss_ptr_d;
   logic [PW-1:0]         ack_ptr_q, ack_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  hit_s2_q, hit_s2_d;
   logic [DATA_WIDTH-1:0] data_s2_q, data_s2_d;

   logic                  push_rdy;
   logic                  push_fire;
   logic                  req_val;
   logic                  issue_fire;
   logic                  ack_fire;
   logic                  lk_hit;
   logic [DATA_WIDTH-1:0] lk_data;
   logic [PW-1:0]         lk_idx;

   // Readiness depends on registered count only, so a same-cycle ack never
   // opens a slot in a full buffer.
   assign push_rdy   = (count_q < DEPTH_C);
   assign push_fire  = vc_wbb_push_val & push_rdy;
   assign req_val    = (state_q[iss_ptr_q] == ST_PENDING);
   assign issue_fire = req_val & noc_wbb_req_rdy;
   // Ack qualifies on the start-of-cycle state, so an entry issued this same
   // cycle cannot be freed by it, and stray acks are ignored.
   assign ack_fire   = noc_wbb_ack_val & (state_q[ack_ptr_q] == ST_ISSUED);

   // NOTE: every signal written in a combinational block gets a default at the
   // top; a path that leaves one unassigned would infer a latch.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      data_d     = data_q;
      wr_ptr_d   = wr_ptr_q;
      iss_ptr_d  = iss_ptr_q;
      ack_ptr_d  = ack_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (vc_wbb_push_val & ~push_rdy);

      // Issue, ack and push always touch distinct entries (PENDING, ISSUED
      // and FREE respectively), so the three updates never collide.
      if (issue_fire) begin
         state_d[iss_ptr_q] = ST_ISSUED;
         iss_ptr_d          = iss_ptr_q + PTR_ONE;
      end
      if (ack_fire) begin
         state_d[ack_ptr_q] = ST_FREE;
         ack_ptr_d          = ack_ptr_q + PTR_ONE;
      end
      if (push_fire) begin
         state_d[wr_ptr_q] = ST_PENDING;
         addr_d[wr_ptr_q]  = vc_wbb_push_addr;
         data_d[wr_ptr_q]  = vc_wbb_push_data;
         wr_ptr_d          = wr_ptr_q + PTR_ONE;
      end

      unique case ({push_fire, ack_fire})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Lookup: walk from oldest (ack_ptr) to youngest so later matches override
   // earlier ones; the same-cycle push is younger than every stored entry.
   always_comb begin
      lk_hit  = 1'b0;
      lk_data = '0;
      lk_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         lk_idx = ack_ptr_q + PW'(i);
         if ((state_q[lk_idx] != ST_FREE) &&
             (addr_q[lk_idx] == l15_wbb_lookup_addr_s1)) begin
            lk_hit  = 1'b1;
            lk_data = data_q[lk_idx];
         end
      end
      if (push_fire && (vc_wbb_push_addr == l15_wbb_lookup_addr_s1)) begin
         lk_hit  = 1'b1;
         lk_data = vc_wbb_push_data;
      end
      hit_s2_d  = l15_wbb_lookup_val_s1 & lk_hit;
      data_s2_d = hit_s2_d ? lk_data : '0;
   end

   // NOTE: sequential state is written only with non-blocking assignments so
   // every flop samples the pre-edge values regardless of statement order.
   // NOTE: the entry storage is reset along with its state because request and
   // lookup outputs read it directly and must show 0 out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            state_q[i] <= ST_FREE;
            addr_q[i]  <= '0;
            data_q[i]  <= '0;
         end
         wr_ptr_q   <= '0;
         iss_ptr_q  <= '0;
         ack_ptr_q  <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         hit_s2_q   <= 1'b0;
         data_s2_q  <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         wr_ptr_q   <= wr_ptr_d;
         iss_ptr_q  <= iss_ptr_d;
         ack_ptr_q  <= ack_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         hit_s2_q   <= hit_s2_d;
         data_s2_q  <= data_s2_d;
      end
   end

   assign wbb_vc_push_rdy  = push_rdy;
   assign wbb_noc_req_val  = req_val;
   assign wbb_noc_req_addr = addr_q[iss_ptr_q];
   assign wbb_noc_req_data = data_q[iss_ptr_q];
   assign wbb_l15_hit_s2   = hit_s2_q;
   assign wbb_l15_data_s2  = data_s2_q;
   assign wbb_empty        = (count_q == '0);
   assign wbb_overflow     = overflow_q;

endmodule

// File: tb/tb_vc_writeback_buffer.sv
// -----------------------------------------------------------------------------
// tb_vc_writeback_buffer
//
// Scoreboard bench for vc_writeback_buffer. The reference model is a queue of
// outstanding lines in push order (oldest first) with an "issued" flag; the
// expected NoC writeback stream and expected S2 lookup results are queued by
// the stimulus side and compared by an independent monitor.
// -----------------------------------------------------------------------------
module tb_vc_writeback_buffer;

   localparam int AW  = 36;
   localparam int DW  = 128;
   localparam int DEP = 4;

   logic          clk;
   logic          rst_n;
   logic          push_val;
   logic [AW-1:0] push_addr;
   logic [DW-1:0] push_data;
   logic          push_rdy;
   logic          lk_val;
   logic [AW-1:0] lk_addr;
   logic          hit_s2;
   logic [DW-1:0] data_s2;
   logic          req_val;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_data;
   logic          noc_rdy;
   logic          ack_val;
   logic          empty;
   logic          overflow;

   vc_writeback_buffer #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .DEPTH      (DEP)
   ) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .vc_wbb_push_val        (push_val),
      .vc_wbb_push_addr       (push_addr),
      .vc_wbb_push_data       (push_data),
      .wbb_vc_push_rdy        (push_rdy),
      .l15_wbb_lookup_val_s1  (lk_val),
      .l15_wbb_lookup_addr_s1 (lk_addr),
      .wbb_l15_hit_s2         (hit_s2),
      .wbb_l15_data_s2        (data_s2),
      .wbb_noc_req_val        (req_val),
      .wbb_noc_req_addr       (req_addr),
      .wbb_noc_req_data       (req_data),
      .noc_wbb_req_rdy        (noc_rdy),
      .noc_wbb_ack_val        (ack_val),
      .wbb_empty              (empty),
      .wbb_overflow           (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      bit            issued;
   } ment_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_t;

   typedef struct {
      int            tgt;
      logic          hit;
      logic [DW-1:0] data;
   } lk_t;

   ment_t mq[$];
   wb_t   exp_wb_q[$];
   lk_t   exp_lk_q[$];
   bit    ov_m = 1'b0;

   function automatic int n_issued();
      int n = 0;
      foreach (mq[i]) if (mq[i].issued) n++;
      return n;
   endfunction

   // Called mid-cycle with this cycle's inputs applied: compares the
   // registered-state outputs, then advances the model across the next edge.
   task automatic model_step();
      int    ni;
      bit    rdy_e, val_e, fire, hit;
      logic [DW-1:0] d;
      ment_t e;
      wb_t   w;
      lk_t   l;
      ni    = n_issued();
      rdy_e = (mq.size() < DEP);
      val_e = (ni < mq.size());
      check("push_rdy", DW'(push_rdy), DW'(rdy_e));
      check("empty",    DW'(empty),    DW'(mq.size() == 0));
      check("overflow", DW'(overflow), DW'(ov_m));
      check("req_val",  DW'(req_val),  DW'(val_e));
      fire = push_val && rdy_e;

      hit = 1'b0;
      d   = '0;
      if (lk_val) begin
         foreach (mq[i]) if (mq[i].addr == lk_addr) begin hit = 1'b1; d = mq[i].data; end
         if (fire && push_addr == lk_addr) begin hit = 1'b1; d = push_data; end
      end
      l.tgt = cyc + 1; l.hit = hit; l.data = d;
      exp_lk_q.push_back(l);

      if (val_e && noc_rdy) mq[ni].issued = 1'b1;
      if (ack_val && ni > 0) void'(mq.pop_front());
      if (fire) begin
         e.addr = push_addr; e.data = push_data; e.issued = 1'b0;
         mq.push_back(e);
         w.addr = push_addr; w.data = push_data;
         exp_wb_q.push_back(w);
      end else if (push_val) begin
         ov_m = 1'b1;
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (exp_lk_q.size() > 0 && exp_lk_q[0].tgt == cyc) begin
            lk_t l;
            l = exp_lk_q.pop_front();
            check("hit_s2",  DW'(hit_s2), DW'(l.hit));
            check("data_s2", data_s2,     l.data);
         end
         if (req_val && noc_rdy) begin
            if (exp_wb_q.size() == 0) begin
               check("wb_spurious", DW'(1), DW'(0));
            end else begin
               wb_t w;
               w = exp_wb_q.pop_front();
               check("wb_addr", DW'(req_addr), DW'(w.addr));
               check("wb_data", req_data,      w.data);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                        input bit lv, input logic [AW-1:0] la, input bit rdy, input bit ack);
      push_val  = pv;
      push_addr = pa;
      push_data = pd;
      lk_val    = lv;
      lk_addr   = la;
      noc_rdy   = rdy;
      ack_val   = ack;
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit rdy, input bit ack);
      drive(1'b0, '0, '0, 1'b0, '0, rdy, ack);
   endtask

   function automatic logic [DW-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_push_rdy"}, DW'(push_rdy), DW'(1));
      check({tag, "_req_val"},  DW'(req_val),  DW'(0));
      check({tag, "_req_addr"}, DW'(req_addr), DW'(0));
      check({tag, "_req_data"}, req_data,      DW'(0));
      check({tag, "_hit_s2"},   DW'(hit_s2),   DW'(0));
      check({tag, "_data_s2"},  data_s2,       DW'(0));
      check({tag, "_empty"},    DW'(empty),    DW'(1));
      check({tag, "_overflow"}, DW'(overflow), DW'(0));
   endtask

   task automatic do_reset(input string tag);
      rst_n     = 1'b0;
      push_val  = 1'b0;
      push_addr = '0;
      push_data = '0;
      lk_val    = 1'b0;
      lk_addr   = '0;
      noc_rdy   = 1'b0;
      ack_val   = 1'b0;
      #1;
      check_reset_outputs(tag);
      mq.delete();
      exp_wb_q.delete();
      exp_lk_q.delete();
      ov_m = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   logic [DW-1:0] d200, d1, d2;
   logic [AW-1:0] ra;
   logic [AW-1:0] la;

   initial begin
      rst_n = 1'b1;
      #2;
      do_reset("rst0");

      // Single line round trip; ack one cycle after the issue.
      drive(1'b1, 36'h000000100, {4{32'hAAAAAAAA}}, 1'b0, '0, 1'b1, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b1);
      idle(1'b0, 1'b0);

      // Fill with the NoC stalled, overflow on the 5th push, then drain.
      for (int k = 1; k <= 4; k++)
         drive(1'b1, AW'(36'h1000 + k), rnd_data(), 1'b0, '0, 1'b0, 1'b0);
      drive(1'b1, 36'h1fff, rnd_data(), 1'b0, '0, 1'b0, 1'b0);
      repeat (8) idle(1'b1, 1'b1);

      // Lookup hits while pending, issued, and on the ack cycle; miss after.
      d200 = rnd_data();
      drive(1'b1, 36'h200, d200, 1'b0, '0, 1'b0, 1'b0);
      drive(1'b0, '0, '0, 1'b1, 36'h200, 1'b0, 1'b0);
      drive(1'b0, '0, '0, 1'b1, 36'h200, 1'b1, 1'b0);
      drive(1'b0, '0, '0, 1'b1, 36'h200, 1'b0, 1'b0);
      drive(1'b0, '0, '0, 1'b1, 36'h200, 1'b0, 1'b1);
      drive(1'b0, '0, '0, 1'b1, 36'h200, 1'b0, 1'b0);
      idle(1'b0, 1'b0);

      // Same-cycle bypass, then youngest duplicate wins.
      d1 = rnd_data();
      d2 = rnd_data();
      drive(1'b1, 36'h300, d1, 1'b1, 36'h300, 1'b0, 1'b0);
      drive(1'b1, 36'h300, d2, 1'b0, '0, 1'b0, 1'b0);
      drive(1'b0, '0, '0, 1'b1, 36'h300, 1'b0, 1'b0);
      repeat (6) idle(1'b1, 1'b1);

      // Randomized traffic over a small address pool to force duplicates.
      for (int n = 0; n < 1500; n++) begin
         ra = AW'(36'h100 * (1 + $urandom_range(0, 5)));
         la = AW'(36'h100 * (1 + $urandom_range(0, 5)));
         drive($urandom_range(0, 99) < 55, ra, rnd_data(),
               $urandom_range(0, 1) == 1, la,
               $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1);
      end
      repeat (2 * DEP + 4) idle(1'b1, 1'b1);
      check("wb_drained", DW'(exp_wb_q.size()), DW'(0));

      // Reset with three lines outstanding, then a stray ack.
      for (int k = 0; k < 3; k++)
         drive(1'b1, AW'(36'h400 + k), rnd_data(), 1'b0, '0, 1'b0, 1'b0);
      drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
      do_reset("rst_mid");
      idle(1'b1, 1'b1);
      idle(1'b1, 1'b0);
      check_reset_outputs("post_ack");
      drive(1'b1, 36'h500, rnd_data(), 1'b0, '0, 1'b1, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b0, 1'b1);
      idle(1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
